// File: rtl/sha256_block_sched.sv
// rtl/sha256_block_sched.sv - SHA-256 block sequencer: round counter, init/IV select, final-add window, digest handshake
module sha256_block_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  input  logic        blk_first,
  input  logic        blk_last,
  output logic        blk_ready,
  input  logic        abort,
  output logic        core_init,
  output logic        use_iv,
  output logic        core_round_en,
  output logic [6:0]  counter_iteration,
  output logic        digest_add,
  output logic        hash_valid,
  input  logic        hash_ready,
  output logic        busy,
  output logic [15:0] blk_cnt,
  output logic        seq_err
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_OUT_WAIT} state_t;

  state_t      r_state, w_next;
  logic        r_last, r_msg_open;
  logic        r_core_init, r_use_iv, r_round_en, r_digest_add, r_hash_valid, r_busy, r_seq_err;
  logic [6:0]  r_ctr, w_ctr_next;
  logic [15:0] r_blk_cnt;
  logic        w_accept;

  assign blk_ready = rst && (r_state == S_IDLE);
  // abort wins over an offered block even though blk_ready is high
  assign w_accept  = blk_valid && blk_ready && !abort;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_accept) w_next = S_INIT;
        S_INIT:     w_next = S_ROUND;
        S_ROUND:    if (r_ctr == 7'd63) w_next = S_FINAL;
        S_FINAL:    w_next = r_last ? S_OUT_WAIT : S_IDLE;
        S_OUT_WAIT: if (hash_ready) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ctr_next = 7'd0;
    if (w_next == S_ROUND && r_state == S_ROUND) w_ctr_next = r_ctr + 7'd1;
    else if (w_next == S_FINAL)                  w_ctr_next = 7'd64;
  end

  // Strobes are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_init  <= 1'b0;
      r_use_iv     <= 1'b0;
      r_round_en   <= 1'b0;
      r_digest_add <= 1'b0;
      r_hash_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_ctr        <= 7'd0;
      r_blk_cnt    <= 16'd0;
      r_seq_err    <= 1'b0;
      r_msg_open   <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_core_init  <= (w_next == S_INIT);
      r_round_en   <= (w_next == S_ROUND);
      r_digest_add <= (w_next == S_FINAL);
      r_hash_valid <= (w_next == S_OUT_WAIT);
      r_busy       <= (w_next != S_IDLE);
      r_ctr        <= w_ctr_next;
      r_use_iv     <= 1'b0;
      if (w_accept) begin
        r_last   <= blk_last;
        r_use_iv <= blk_first || !r_msg_open;
        if (blk_first)                r_blk_cnt <= 16'd1;
        else if (r_blk_cnt != 16'hFFFF) r_blk_cnt <= r_blk_cnt + 16'd1;
        if (!blk_first && !r_msg_open) r_seq_err <= 1'b1;
      end
      if (r_state == S_FINAL) r_msg_open <= !r_last;
      if (abort) begin
        r_msg_open <= 1'b0;
        r_blk_cnt  <= 16'd0;
      end
    end
  end

  assign core_init         = r_core_init;
  assign use_iv            = r_use_iv;
  assign core_round_en     = r_round_en;
  assign counter_iteration = r_ctr;
  assign digest_add        = r_digest_add;
  assign hash_valid        = r_hash_valid;
  assign busy              = r_busy;
  assign blk_cnt           = r_blk_cnt;
  assign seq_err           = r_seq_err;

endmodule

// File: tb/tb_sha256_block_sched.sv
// tb/tb_sha256_block_sched.sv - directed bench for the SHA-256 block sequencer
module tb_sha256_block_sched;

  logic        clk = 1'b0;
  logic        rst, blk_valid, blk_first, blk_last, abort, hash_ready;
  logic        blk_ready, core_init, use_iv, core_round_en, digest_add, hash_valid, busy, seq_err;
  logic [6:0]  counter_iteration;
  logic [15:0] blk_cnt;
  int          tests_run = 0;
  int          tests_failed = 0;

  sha256_block_sched dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
    .blk_ready(blk_ready), .abort(abort), .core_init(core_init), .use_iv(use_iv),
    .core_round_en(core_round_en), .counter_iteration(counter_iteration), .digest_add(digest_add),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .busy(busy), .blk_cnt(blk_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Offers a block at a falling edge; returns at the falling edge of the INIT cycle
  task automatic send_block(input logic first, input logic last);
    blk_valid = 1'b1; blk_first = first; blk_last = last;
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
  endtask

  task automatic test_reset;
    logic [33:0] outs;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {blk_ready, core_init, use_iv, core_round_en, counter_iteration, digest_add,
            hash_valid, busy, blk_cnt, seq_err};
    tests_run++;
    if (outs !== 34'd0) begin tests_failed++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (blk_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release ready=%b busy=%b want 1/0", blk_ready, busy);
    end
  endtask

  task automatic test_single_block;
    hash_ready = 1'b1;
    send_block(1'b1, 1'b1);
    tests_run++;
    if (core_init !== 1'b1 || use_iv !== 1'b1 || counter_iteration !== 7'd0 || busy !== 1'b1 || blk_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_init init=%b iv=%b ctr=%0d busy=%b cnt=%0d want 1/1/0/1/1",
               core_init, use_iv, counter_iteration, busy, blk_cnt);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      tests_run++;
      if (core_round_en !== 1'b1 || counter_iteration !== i[6:0] || digest_add !== 1'b0 || core_init !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_round%0d en=%b ctr=%0d add=%b init=%b want 1/%0d/0/0",
                 i, core_round_en, counter_iteration, digest_add, core_init, i);
      end
    end
    @(negedge clk);
    tests_run++;
    if (digest_add !== 1'b1 || counter_iteration !== 7'd64 || core_round_en !== 1'b0 || hash_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_final add=%b ctr=%0d en=%b hv=%b want 1/64/0/0",
               digest_add, counter_iteration, core_round_en, hash_valid);
    end
    @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b1 || digest_add !== 1'b0 || counter_iteration !== 7'd0 || blk_ready !== 1'b0 || blk_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_out hv=%b add=%b ctr=%0d rdy=%b cnt=%0d want 1/0/0/0/1",
               hash_valid, digest_add, counter_iteration, blk_ready, blk_cnt);
    end
    @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_done hv=%b rdy=%b busy=%b want 0/1/0", hash_valid, blk_ready, busy);
    end
  endtask

  task automatic test_two_block;
    hash_ready = 1'b1;
    send_block(1'b1, 1'b0);
    tests_run++;
    if (use_iv !== 1'b1 || blk_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL two_init1 iv=%b cnt=%0d want 1/1", use_iv, blk_cnt);
    end
    repeat (65) @(negedge clk);
    tests_run++;
    if (digest_add !== 1'b1) begin tests_failed++; $display("FAIL two_final1 add=%b want 1", digest_add); end
    @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL two_gap hv=%b rdy=%b busy=%b want 0/1/0", hash_valid, blk_ready, busy);
    end
    send_block(1'b0, 1'b1);
    tests_run++;
    if (core_init !== 1'b1 || use_iv !== 1'b0 || blk_cnt !== 16'd2 || seq_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_init2 init=%b iv=%b cnt=%0d err=%b want 1/0/2/0", core_init, use_iv, blk_cnt, seq_err);
    end
    repeat (66) @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b1 || blk_cnt !== 16'd2) begin
      tests_failed++; $display("FAIL two_out hv=%b cnt=%0d want 1/2", hash_valid, blk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_restart;
    hash_ready = 1'b1;
    send_block(1'b1, 1'b0);
    repeat (66) @(negedge clk);
    send_block(1'b1, 1'b1);
    tests_run++;
    if (use_iv !== 1'b1 || blk_cnt !== 16'd1 || seq_err !== 1'b0) begin
      tests_failed++; $display("FAIL restart iv=%b cnt=%0d err=%b want 1/1/0", use_iv, blk_cnt, seq_err);
    end
    repeat (67) @(negedge clk);
  endtask

  task automatic test_hash_backpressure;
    hash_ready = 1'b0;
    send_block(1'b1, 1'b1);
    repeat (66) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (hash_valid !== 1'b1 || blk_ready !== 1'b0) begin
        tests_failed++; $display("FAIL hold%0d hv=%b rdy=%b want 1/0", i, hash_valid, blk_ready);
      end
      if (i < 9) @(negedge clk);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b0 || blk_ready !== 1'b1) begin
      tests_failed++; $display("FAIL hold_release hv=%b rdy=%b want 0/1", hash_valid, blk_ready);
    end
  endtask

  task automatic test_abort;
    hash_ready = 1'b1;
    send_block(1'b1, 1'b1);
    repeat (31) @(negedge clk);
    tests_run++;
    if (counter_iteration !== 7'd30) begin
      tests_failed++; $display("FAIL abort_pre ctr=%0d want 30", counter_iteration);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (counter_iteration !== 7'd0 || core_round_en !== 1'b0 || digest_add !== 1'b0 || hash_valid !== 1'b0 ||
        blk_cnt !== 16'd0 || busy !== 1'b0 || blk_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_post ctr=%0d en=%b add=%b hv=%b cnt=%0d busy=%b rdy=%b want 0/0/0/0/0/0/1",
               counter_iteration, core_round_en, digest_add, hash_valid, blk_cnt, busy, blk_ready);
    end
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1; abort = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0; abort = 1'b0;
    tests_run++;
    if (core_init !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL abort_idle init=%b busy=%b cnt=%0d want 0/0/0", core_init, busy, blk_cnt);
    end
    send_block(1'b1, 1'b1);
    tests_run++;
    if (core_init !== 1'b1 || use_iv !== 1'b1) begin
      tests_failed++; $display("FAIL abort_resend init=%b iv=%b want 1/1", core_init, use_iv);
    end
    repeat (65) @(negedge clk);
    tests_run++;
    if (digest_add !== 1'b1 || counter_iteration !== 7'd64) begin
      tests_failed++; $display("FAIL abort_resend_final add=%b ctr=%0d want 1/64", digest_add, counter_iteration);
    end
    @(negedge clk);
    tests_run++;
    if (hash_valid !== 1'b1 || blk_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL abort_resend_out hv=%b cnt=%0d want 1/1", hash_valid, blk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_seq_err;
    send_block(1'b0, 1'b1);
    tests_run++;
    if (seq_err !== 1'b1 || use_iv !== 1'b1 || core_init !== 1'b1) begin
      tests_failed++; $display("FAIL seq_err_set err=%b iv=%b init=%b want 1/1/1", seq_err, use_iv, core_init);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (seq_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL seq_err_abort err=%b busy=%b want 1/0", seq_err, busy);
    end
  endtask

  task automatic test_reset_mid_round;
    logic [33:0] outs;
    send_block(1'b1, 1'b1);
    repeat (41) @(negedge clk);
    tests_run++;
    if (counter_iteration !== 7'd40) begin
      tests_failed++; $display("FAIL rst_mid_pre ctr=%0d want 40", counter_iteration);
    end
    rst = 1'b0;
    @(negedge clk);
    outs = {blk_ready, core_init, use_iv, core_round_en, counter_iteration, digest_add,
            hash_valid, busy, blk_cnt, seq_err};
    tests_run++;
    if (outs !== 34'd0) begin tests_failed++; $display("FAIL rst_mid_outputs got %h want 0", outs); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (blk_ready !== 1'b1 || seq_err !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_release rdy=%b err=%b want 1/0", blk_ready, seq_err);
    end
  endtask

  initial begin
    rst = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; abort = 1'b0; hash_ready = 1'b0;
    test_reset();
    test_single_block();
    test_two_block();
    test_restart();
    test_hash_backpressure();
    test_abort();
    test_seq_err();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
